sram_mem_adapter: RTL and testbench

//   Sits between the AXI-to-memory converter's word interface and the single-port SRAM wrapper in the memory subsystem.

---
 rtl/sram_mem_adapter_pkg.sv | 22 ++
 rtl/sram_rmw_merge.sv | 19 +
 rtl/sram_mem_adapter.sv | 142 ++++++++++++++
 tb/tb_sram_mem_adapter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_adapter_pkg.sv
// Shared types and helpers for the SRAM word adapter and its optional
// read-modify-write byte merge.
package sram_mem_adapter_pkg;

   localparam int unsigned MaxStrbWidth = 128;
   localparam int unsigned MaxDataWidth = MaxStrbWidth * 8;

   typedef enum logic {
      IDLE,
      MERGE
   } rmw_state_e;

   // Callers zero-extend their strobes and truncate the result to their own width.
   function automatic logic [MaxDataWidth-1:0] strb_to_mask(input logic [MaxStrbWidth-1:0] strb);
      logic [MaxDataWidth-1:0] mask;
      for (int i = 0; i < MaxStrbWidth; i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/sram_rmw_merge.sv
// Combinational byte merge: strobed bytes come from the new write data,
// all other bytes keep the word just read from the SRAM.
module sram_rmw_merge
   import sram_mem_adapter_pkg::*;
#(
   parameter int unsigned DataWidth = 64
) (
   input  logic [DataWidth-1:0]   old_data_i,
   input  logic [DataWidth-1:0]   new_data_i,
   input  logic [DataWidth/8-1:0] strb_i,
   output logic [DataWidth-1:0]   merged_o
);

   logic [DataWidth-1:0] mask;

   assign mask     = DataWidth'(strb_to_mask(MaxStrbWidth'(strb_i)));
   assign merged_o = (old_data_i & ~mask) | (new_data_i & mask);

endmodule

// File: rtl/sram_mem_adapter.sv
// Word-interface to single-port SRAM adapter with fixed 1-cycle read latency.
// Define SRAM_MEM_ADAPTER_RMW_EN to emulate byte strobes with read-modify-write.
module sram_mem_adapter
   import sram_mem_adapter_pkg::*;
#(
   parameter int unsigned AddrWidth = 13,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   mem_req_i,
   output logic                   mem_gnt_o,
   input  logic [AddrWidth-1:0]   mem_addr_i,
   input  logic                   mem_we_i,
   input  logic [DataWidth-1:0]   mem_wdata_i,
   input  logic [DataWidth/8-1:0] mem_strb_i,
   output logic                   mem_rvalid_o,
   output logic [DataWidth-1:0]   mem_rdata_o,
   output logic                   sram_req_o,
   output logic                   sram_we_o,
   output logic [AddrWidth-1:0]   sram_addr_o,
   output logic [DataWidth-1:0]   sram_wdata_o,
   output logic [DataWidth/8-1:0] sram_be_o,
   input  logic [DataWidth-1:0]   sram_rdata_i,
   output logic                   busy_o,
   output logic [CntWidth-1:0]    rmw_count_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;

   logic rvalid_q, rvalid_d;
   logic strb_zero;

   assign strb_zero    = (mem_strb_i == '0);
   assign rvalid_d     = mem_req_i & mem_gnt_o;
   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = sram_rdata_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rvalid_d;
      end
   end

`ifdef SRAM_MEM_ADAPTER_RMW_EN

   rmw_state_e           state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic [StrbWidth-1:0] strb_q, strb_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic [DataWidth-1:0] merged;
   logic                 partial;

   assign partial = mem_we_i & ~strb_zero & ~(&mem_strb_i);

   sram_rmw_merge #(
      .DataWidth (DataWidth)
   ) u_merge (
      .old_data_i (sram_rdata_i),
      .new_data_i (wdata_q),
      .strb_i     (strb_q),
      .merged_o   (merged)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      strb_d       = strb_q;
      cnt_d        = cnt_q;
      mem_gnt_o    = mem_req_i;
      sram_req_o   = mem_req_i & ~(mem_we_i & strb_zero);
      sram_we_o    = mem_we_i;
      sram_addr_o  = mem_addr_i;
      sram_wdata_o = mem_wdata_i;
      sram_be_o    = '1;
      case (state_q)
         IDLE: begin
            // Partial write: hold off the grant and fetch the old word first.
            if (mem_req_i && partial) begin
               mem_gnt_o = 1'b0;
               sram_we_o = 1'b0;
               addr_d    = mem_addr_i;
               wdata_d   = mem_wdata_i;
               strb_d    = mem_strb_i;
               state_d   = MERGE;
            end
         end
         MERGE: begin
            mem_gnt_o    = 1'b1;
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = addr_q;
            sram_wdata_o = merged;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CntWidth'(1);
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o      = rvalid_q | (state_q == MERGE);
   assign rmw_count_o = cnt_q;

`else

   assign mem_gnt_o    = mem_req_i;
   assign sram_req_o   = mem_req_i & ~(mem_we_i & strb_zero);
   assign sram_we_o    = mem_we_i;
   assign sram_addr_o  = mem_addr_i;
   assign sram_wdata_o = mem_wdata_i;
   assign sram_be_o    = mem_strb_i;
   assign busy_o       = rvalid_q;
   assign rmw_count_o  = '0;

`endif

endmodule

// File: tb/tb_sram_mem_adapter.sv
// Randomized bench for sram_mem_adapter with a behavioural memory model and
// a small SRAM model; works with or without SRAM_MEM_ADAPTER_RMW_EN.
module tb_sram_mem_adapter;

   localparam int AW = 13;
   localparam int DW = 64;
   localparam int SW = 8;
   localparam int CW = 3;
   localparam int CntMax = (1 << CW) - 1;
`ifdef SRAM_MEM_ADAPTER_RMW_EN
   localparam bit RmwEn = 1'b1;
`else
   localparam bit RmwEn = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          mem_req_i;
   logic          mem_gnt_o;
   logic [AW-1:0] mem_addr_i;
   logic          mem_we_i;
   logic [DW-1:0] mem_wdata_i;
   logic [SW-1:0] mem_strb_i;
   logic          mem_rvalid_o;
   logic [DW-1:0] mem_rdata_o;
   logic          sram_req_o;
   logic          sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [DW-1:0] sram_wdata_o;
   logic [SW-1:0] sram_be_o;
   logic [DW-1:0] sram_rdata_i;
   logic          busy_o;
   logic [CW-1:0] rmw_count_o;

   always #5 clk_i = ~clk_i;

   sram_mem_adapter #(
      .AddrWidth (AW),
      .DataWidth (DW),
      .CntWidth  (CW)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .mem_req_i    (mem_req_i),
      .mem_gnt_o    (mem_gnt_o),
      .mem_addr_i   (mem_addr_i),
      .mem_we_i     (mem_we_i),
      .mem_wdata_i  (mem_wdata_i),
      .mem_strb_i   (mem_strb_i),
      .mem_rvalid_o (mem_rvalid_o),
      .mem_rdata_o  (mem_rdata_o),
      .sram_req_o   (sram_req_o),
      .sram_we_o    (sram_we_o),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_be_o    (sram_be_o),
      .sram_rdata_i (sram_rdata_i),
      .busy_o       (busy_o),
      .rmw_count_o  (rmw_count_o)
   );

   // SRAM model with a backdoor port used only to preload words.
   logic [DW-1:0] sram_mem [0:(1<<AW)-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;

   always @(posedge clk_i) begin
      if (bd_we) begin
         sram_mem[bd_addr] <= bd_data;
      end else if (sram_req_o) begin
         if (sram_we_o) begin
            for (int b = 0; b < SW; b++) begin
               if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end
         end else begin
            sram_rdata_i <= sram_mem[sram_addr_o];
         end
      end
   end

   typedef struct packed {
      bit            idle;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] strb;
   } txn_t;

   logic [DW-1:0] gold [0:(1<<AW)-1];
   txn_t          seq_q[$];
   int            model_cnt = 0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            n_txn = 0;
   bit            exp_rv;
   bit            exp_rd_chk;
   logic [DW-1:0] exp_rd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] r;
      r = old_w;
      for (int b = 0; b < SW; b++) begin
         if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return r;
   endfunction

   task automatic backdoor(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bd_we   = 1'b1;
      bd_addr = addr;
      bd_data = data;
      gold[addr] = data;
      @(posedge clk_i);
      #1;
      bd_we = 1'b0;
   endtask

   function automatic txn_t mk(input bit we, input int addr, input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
      txn_t t;
      t.idle  = 1'b0;
      t.we    = we;
      t.addr  = AW'(addr);
      t.wdata = wdata;
      t.strb  = strb;
      return t;
   endfunction

   // Drives seq_q back to back; each cycle checks grant, SRAM port and response.
   task automatic run_seq();
      int            idx = 0;
      int            waited = 0;
      int            lat;
      bit            partial;
      bit            sram_exp;
      txn_t          t;
      logic [DW-1:0] new_word;
      exp_rv = 1'b0;
      while (idx < seq_q.size() || exp_rv) begin
         if (idx < seq_q.size()) t = seq_q[idx];
         else t = '0;
         mem_req_i   = (idx < seq_q.size()) && !t.idle;
         mem_we_i    = t.we;
         mem_addr_i  = t.addr;
         mem_wdata_i = t.wdata;
         mem_strb_i  = t.strb;
         @(negedge clk_i);
         chk("rvalid", 64'(mem_rvalid_o), 64'(exp_rv));
         if (exp_rv && exp_rd_chk) chk("rdata", mem_rdata_o, exp_rd);
         chk("rmw_count", 64'(rmw_count_o), 64'(model_cnt));
         exp_rv = 1'b0;
         if (mem_req_i) begin
            partial = t.we && (t.strb != '0) && (t.strb != '1);
            lat = (RmwEn && partial) ? 1 : 0;
            if (waited < lat) begin
               chk("gnt_rmw_read", 64'(mem_gnt_o), 64'(0));
               chk("sram_req_rmw_read", 64'(sram_req_o), 64'(1));
               chk("sram_we_rmw_read", 64'(sram_we_o), 64'(0));
               chk("sram_addr_rmw_read", 64'(sram_addr_o), 64'(t.addr));
               waited++;
            end else begin
               new_word = t.we ? apply_strb(gold[t.addr], t.wdata, t.strb) : gold[t.addr];
               sram_exp = !(t.we && t.strb == '0);
               chk("gnt", 64'(mem_gnt_o), 64'(1));
               chk("sram_req", 64'(sram_req_o), 64'(sram_exp));
               if (sram_exp) begin
                  chk("sram_we", 64'(sram_we_o), 64'(t.we));
                  chk("sram_addr", 64'(sram_addr_o), 64'(t.addr));
                  chk("sram_be", 64'(sram_be_o), RmwEn ? 64'hFF : 64'(t.strb));
                  if (t.we) chk("sram_wdata", sram_wdata_o, RmwEn ? new_word : t.wdata);
               end
               exp_rv     = 1'b1;
               exp_rd_chk = !t.we;
               exp_rd     = gold[t.addr];
               if (t.we) gold[t.addr] = new_word;
               if (RmwEn && partial && model_cnt < CntMax) model_cnt++;
               $display("txn %0d: %s addr=%h wdata=%h strb=%h grant_wait=%0d", n_txn, t.we ? "WR" : "RD",
                        t.addr, t.wdata, t.strb, lat);
               n_txn++;
               idx++;
               waited = 0;
            end
         end else begin
            chk("gnt_idle", 64'(mem_gnt_o), 64'(0));
            if (idx < seq_q.size()) idx++;
         end
         @(posedge clk_i);
         #1;
      end
      mem_req_i = 1'b0;
      seq_q.delete();
   endtask

   initial begin
      txn_t    t;
      int      r;
      logic [AW-1:0] a6;
      rst_i       = 1'b1;
      mem_req_i   = 1'b0;
      mem_we_i    = 1'b0;
      mem_addr_i  = '0;
      mem_wdata_i = '0;
      mem_strb_i  = '0;
      #1;
      for (int a = 0; a < 32; a++) backdoor(AW'(a), {$urandom, $urandom});
      backdoor(AW'(16), 64'hDEAD_BEEF_0123_4567);

      @(negedge clk_i);
      chk("reset_rvalid", 64'(mem_rvalid_o), 64'(0));
      chk("reset_busy", 64'(busy_o), 64'(0));
      chk("reset_rmw_count", 64'(rmw_count_o), 64'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // T1 single read, T2 streaming reads
      seq_q.push_back(mk(1'b0, 16, '0, '0));
      run_seq();
      for (int a = 0; a < 8; a++) seq_q.push_back(mk(1'b0, a, '0, '0));
      run_seq();

      // T3 full write then read
      seq_q.push_back(mk(1'b1, 5, 64'h1122_3344_5566_7788, 8'hFF));
      seq_q.push_back(mk(1'b0, 5, '0, '0));
      run_seq();

      // T4 partial write immediately followed by a read of the same word
      backdoor(AW'(9), 64'hFFFF_FFFF_FFFF_FFFF);
      seq_q.push_back(mk(1'b1, 9, 64'h0000_0000_0000_00AB, 8'h01));
      seq_q.push_back(mk(1'b0, 9, '0, '0));
      run_seq();
      chk("t4_word", sram_mem[9], 64'hFFFF_FFFF_FFFF_FFAB);

      // T5 zero-strobe write leaves memory untouched
      seq_q.push_back(mk(1'b1, 3, {$urandom, $urandom}, 8'h00));
      seq_q.push_back(mk(1'b0, 3, '0, '0));
      run_seq();
      chk("t5_word", sram_mem[3], gold[3]);

      // Random mix, long enough to saturate the small RMW counter
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 3));
         t = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), {$urandom, $urandom},
                (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom));
         t.idle = ($urandom_range(0, 9) == 0);
         seq_q.push_back(t);
      end
      run_seq();
      for (int a = 0; a < 32; a++) chk("mem_final", sram_mem[a], gold[a]);
      chk("idle_busy", 64'(busy_o), 64'(0));

      // T6 reset during the grant (MERGE) cycle of a partial write
      a6 = AW'(7);
      backdoor(a6, 64'hFFFF_FFFF_FFFF_FFFF);
      mem_req_i   = 1'b1;
      mem_we_i    = 1'b1;
      mem_addr_i  = a6;
      mem_wdata_i = {$urandom, $urandom};
      mem_strb_i  = 8'h3C;
      @(negedge clk_i);
      if (RmwEn) begin
         @(posedge clk_i);
         #1;
         @(negedge clk_i);
      end
      rst_i     = 1'b1;
      mem_req_i = 1'b0;
      model_cnt = 0;
      #1;
      chk("t6_no_sram_write", 64'(sram_req_o & sram_we_o), 64'(0));
      chk("t6_rvalid", 64'(mem_rvalid_o), 64'(0));
      chk("t6_busy", 64'(busy_o), 64'(0));
      chk("t6_rmw_count", 64'(rmw_count_o), 64'(model_cnt));
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("t6_rvalid_after_edge", 64'(mem_rvalid_o), 64'(0));
      chk("t6_word", sram_mem[a6], gold[a6]);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      seq_q.push_back(mk(1'b0, 16, '0, '0));
      seq_q.push_back(mk(1'b0, 7, '0, '0));
      run_seq();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
